// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared types for the LC-3b memory hierarchy
package lc3b_types;

  localparam int LC3B_ADDR_WIDTH = 16;
  localparam int LC3B_LINE_WIDTH = 128;

  typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } lc3b_arb_id;

endpackage

// File: rtl/l2_mem_arbiter.sv
// rtl/l2_mem_arbiter.sv - round-robin arbiter sharing the L2 line port between I and D miss paths
module l2_mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_next_state;
  lc3b_arb_id    r_last_grant;
  logic          w_d_req;

  assign w_d_req = d_read | d_write;

  // last_grant only moves when leaving IDLE, so it names the most recent winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= ARB_I;
    end else begin
      r_state <= w_next_state;
      if (r_state == ARB_IDLE && w_next_state == ARB_GRANT_I) begin
        r_last_grant <= ARB_I;
      end else if (r_state == ARB_IDLE && w_next_state == ARB_GRANT_D) begin
        r_last_grant <= ARB_D;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    l2_read      = 1'b0;
    l2_write     = 1'b0;
    l2_address   = '0;
    l2_wdata     = '0;
    i_rdata      = '0;
    i_resp       = 1'b0;
    d_rdata      = '0;
    d_resp       = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (i_read && w_d_req) begin
          w_next_state = (r_last_grant == ARB_I) ? ARB_GRANT_D : ARB_GRANT_I;
        end else if (i_read) begin
          w_next_state = ARB_GRANT_I;
        end else if (w_d_req) begin
          w_next_state = ARB_GRANT_D;
        end
      end

      ARB_GRANT_I: begin
        l2_read    = i_read;
        l2_address = i_address;
        if (l2_resp) begin
          i_resp       = 1'b1;
          i_rdata      = l2_rdata;
          w_next_state = ARB_IDLE;
        end
      end

      ARB_GRANT_D: begin
        // read+write together is illegal; the read wins
        l2_read    = d_read;
        l2_write   = d_write & ~d_read;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        if (l2_resp) begin
          d_resp       = 1'b1;
          d_rdata      = l2_rdata;
          w_next_state = ARB_IDLE;
        end
      end

      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb/tb_l2_mem_arbiter.sv - scoreboard bench for l2_mem_arbiter with an L2 stand-in and random traffic
module tb_l2_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  l2_mem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_i[$];
  logic [127:0] exp_d[$];
  logic [127:0] ref_mem[logic [15:0]];
  logic [127:0] l2_mem[logic [15:0]];
  int lat = 3;
  bit rand_lat = 1'b0;
  bit inject_resp = 1'b0;

  function automatic logic [127:0] line_init(input logic [15:0] a);
    if (a == 16'h0040) return {16{8'hA5}};
    return {8{a ^ 16'h5A5A}};
  endfunction

  function automatic logic [127:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return line_init(a);
  endfunction

  function automatic logic [127:0] l2_line(input logic [15:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    return line_init(a);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    failures++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // L2 stand-in: completes each strobed access after a latency, storing writes
  initial begin
    int cnt;
    int cur;
    bit was_resp;
    cnt = 0;
    cur = 1;
    was_resp = 1'b0;
    l2_resp = 1'b0;
    l2_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      l2_resp = 1'b0;
      l2_rdata = '0;
      if (!rst_n) begin
        cnt = 0;
        was_resp = 1'b0;
      end else if (was_resp) begin
        was_resp = 1'b0;
        cnt = 0;
      end else if (l2_read || l2_write) begin
        if (cnt == 0) cur = rand_lat ? int'($urandom_range(1, 4)) : lat;
        cnt++;
        if (cnt >= cur) begin
          l2_resp = 1'b1;
          was_resp = 1'b1;
          if (l2_read) l2_rdata = l2_line(l2_address);
          else l2_mem[l2_address] = l2_wdata;
        end
      end else if (inject_resp) begin
        l2_resp = 1'b1;
        l2_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: pops the scoreboard on every completion pulse
  initial begin
    int i_wait;
    int d_wait;
    i_wait = 0;
    d_wait = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_wait = 0;
        d_wait = 0;
      end else begin
        chk("strobe_exclusive", 128'(l2_read && l2_write), 128'(0));
        if (i_resp) begin
          if (exp_i.size() == 0) fail_msg("i_resp_unexpected");
          else chk("i_rdata", i_rdata, exp_i.pop_front());
          chk("i_starvation", 128'(i_wait <= 1), 128'(1));
          chk("d_resp_during_i_resp", 128'(d_resp), 128'(0));
          i_wait = 0;
        end else begin
          chk("i_rdata_quiet", i_rdata, 128'(0));
        end
        if (d_resp) begin
          if (exp_d.size() == 0) fail_msg("d_resp_unexpected");
          else chk("d_rdata", d_rdata, exp_d.pop_front());
          chk("d_starvation", 128'(d_wait <= 1), 128'(1));
          d_wait = 0;
        end else begin
          chk("d_rdata_quiet", d_rdata, 128'(0));
        end
        if (d_resp && i_read) i_wait++;
        if (i_resp && (d_read || d_write)) d_wait++;
      end
    end
  end

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(l2_read || l2_write) && n < 50);
    if (!(l2_read || l2_write)) fail_msg("strobe_timeout");
  endtask

  task automatic wait_any_resp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i_resp || d_resp) && n < 50);
    if (!(i_resp || d_resp)) fail_msg("resp_timeout");
  endtask

  task automatic i_xact(input logic [15:0] a);
    int n;
    i_address = a;
    i_read = 1'b1;
    exp_i.push_back(ref_read(a));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_resp && n < 300);
    if (!i_resp) fail_msg("i_xact_timeout");
    @(posedge clk);
    #1;
    i_read = 1'b0;
  endtask

  task automatic d_xact(input logic [15:0] a, input bit wr, input logic [127:0] data);
    int n;
    d_address = a;
    d_wdata = data;
    d_write = wr;
    d_read = !wr;
    if (wr) begin
      ref_mem[a] = data;
      exp_d.push_back('0);
    end else begin
      exp_d.push_back(ref_read(a));
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_resp && n < 300);
    if (!d_resp) fail_msg("d_xact_timeout");
    @(posedge clk);
    #1;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic gap();
    int g;
    g = int'($urandom_range(0, 3));
    if (g > 0) begin
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic [127:0] wb_line;
    rst_n = 1'b0;
    i_read = 1'b1;
    d_read = 1'b1;
    d_write = 1'b0;
    i_address = 16'h0100;
    d_address = 16'h8100;
    d_wdata = '0;
    lat = 2;

    repeat (3) @(negedge clk);
    chk("reset_strobes_resps", 128'({l2_read, l2_write, i_resp, d_resp}), 128'(0));
    chk("reset_l2_address", 128'(l2_address), 128'(0));
    chk("reset_l2_wdata", l2_wdata, 128'(0));
    chk("reset_rdata", i_rdata | d_rdata, 128'(0));

    // both held: grants alternate D, I, D, I with exactly one idle cycle between
    exp_d.push_back(ref_read(16'h8100));
    exp_i.push_back(ref_read(16'h0100));
    exp_d.push_back(ref_read(16'h8100));
    exp_i.push_back(ref_read(16'h0100));
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_strobe(n);
      chk("grant_gap", 128'(n), 128'(1));
      chk("grant_order", 128'(l2_address), (k % 2 == 0) ? 128'(16'h8100) : 128'(16'h0100));
      wait_any_resp();
      if (k == 3) begin
        @(posedge clk);
        #1;
        i_read = 1'b0;
        d_read = 1'b0;
      end
      @(negedge clk);
      chk("idle_after_resp", 128'({l2_read, l2_write}), 128'(0));
    end

    // lone I read, L2 latency 3
    lat = 3;
    @(posedge clk);
    #1;
    i_address = 16'h0040;
    i_read = 1'b1;
    exp_i.push_back({16{8'hA5}});
    @(negedge clk);
    chk("i_latency_idle_cycle", 128'(l2_read), 128'(0));
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (l2_read) begin
        cnt++;
        chk("i_l2_address", 128'(l2_address), 128'(16'h0040));
      end
      if (i_resp) break;
    end
    chk("i_read_cycles", 128'(cnt), 128'(3));
    @(posedge clk);
    #1;
    i_read = 1'b0;

    // stray l2_resp while idle must be ignored
    @(posedge clk);
    #1;
    inject_resp = 1'b1;
    @(negedge clk);
    chk("stray_resp_ignored", 128'({i_resp, d_resp, l2_read, l2_write}), 128'(0));
    @(posedge clk);
    #1;
    inject_resp = 1'b0;
    @(negedge clk);
    chk("stray_resp_state", 128'({l2_read, l2_write}), 128'(0));

    // D writeback
    @(posedge clk);
    #1;
    wb_line = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    d_address = 16'h1F80;
    d_wdata = wb_line;
    d_write = 1'b1;
    ref_mem[16'h1F80] = wb_line;
    exp_d.push_back('0);
    wait_strobe(n);
    chk("wb_strobes", 128'({l2_write, l2_read}), 128'(2'b10));
    chk("wb_wdata", l2_wdata, wb_line);
    chk("wb_address", 128'(l2_address), 128'(16'h1F80));
    wait_any_resp();
    @(posedge clk);
    #1;
    d_write = 1'b0;
    @(negedge clk);
    chk("wb_idle_after", 128'({l2_read, l2_write}), 128'(0));
    @(posedge clk);
    #1;
    d_xact(16'h1F80, 1'b0, '0);

    // reset dropped during GRANT_D abandons the access
    lat = 4;
    d_address = 16'h8200;
    d_read = 1'b1;
    wait_strobe(n);
    #2;
    i_address = 16'h0300;
    i_read = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_strobe", 128'({l2_read, l2_write}), 128'(0));
    chk("reset_no_d_resp", 128'(d_resp), 128'(0));
    @(posedge clk);
    #1;
    d_read = 1'b0;
    @(negedge clk);
    chk("reset_hold_no_d_resp", 128'(d_resp), 128'(0));
    exp_i.push_back(ref_read(16'h0300));
    rst_n = 1'b1;
    wait_strobe(n);
    chk("post_reset_grant_i", 128'({l2_read, l2_address}), 128'({1'b1, 16'h0300}));
    wait_any_resp();
    @(posedge clk);
    #1;
    i_read = 1'b0;

    // random concurrent traffic
    rand_lat = 1'b1;
    fork
      begin
        for (int t = 0; t < 30; t++) begin
          gap();
          i_xact({1'b0, 11'($urandom_range(0, 2047)), 4'h0});
        end
      end
      begin
        for (int t = 0; t < 30; t++) begin
          gap();
          d_xact({1'b1, 7'h0, 4'($urandom_range(0, 15)), 4'h0}, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom});
        end
      end
    join

    repeat (5) @(negedge clk);
    chk("exp_i_drained", 128'(exp_i.size()), 128'(0));
    chk("exp_d_drained", 128'(exp_d.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
